// File: rtl/wbck_ctrl.sv
// Integer register file write-back controller.
// Arbitrates ALU and long-pipe results onto the single write port and tracks
// outstanding long-pipe destinations in a small circular FIFO (OITF) so that
// dispatch can be stalled on RAW/WAW hazards.
module wbck_ctrl #(
  parameter int unsigned OITF_DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(OITF_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        disp_valid,
  output logic        disp_ready,
  input  logic        disp_rdwen,
  input  logic [4:0]  disp_rdidx,
  input  logic [4:0]  disp_rs1idx,
  input  logic [4:0]  disp_rs2idx,
  input  logic        disp_rs1en,
  input  logic        disp_rs2en,
  output logic        oitf_dep,
  output logic        oitf_empty,

  input  logic        alu_wbck_valid,
  output logic        alu_wbck_ready,
  input  logic [4:0]  alu_wbck_idx,
  input  logic [31:0] alu_wbck_dat,

  input  logic        longp_wbck_valid,
  output logic        longp_wbck_ready,
  input  logic [31:0] longp_wbck_dat,

  output logic        wbck_dest_wen,
  output logic [4:0]  wbck_dest_idx,
  output logic [31:0] wbck_dest_dat
);

  // Pointers carry an extra MSB wrap bit to tell full from empty.
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             r_rdwen [OITF_DEPTH];
  logic [4:0]       r_rdidx [OITF_DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_alloc;
  logic             w_retire;
  logic             w_alu_hs;
  logic [PTR_W:0]   w_count;
  logic [PTR_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_rd_idx;
  logic [PTR_W-1:0] w_off   [OITF_DEPTH];
  logic             w_valid [OITF_DEPTH];

  assign w_wr_idx = r_wr_ptr[PTR_W-1:0];
  assign w_rd_idx = r_rd_ptr[PTR_W-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
  assign w_count  = r_wr_ptr - r_rd_ptr;

  // No full-bypass: a same-cycle retire does not free a slot for allocation.
  assign disp_ready       = !w_full;
  assign oitf_empty       = w_empty;
  assign longp_wbck_ready = !w_empty;
  // Long-pipe results are older than any ALU result, so they win the port.
  assign alu_wbck_ready   = !(longp_wbck_valid && !w_empty);

  assign w_alloc  = disp_valid && disp_ready;
  assign w_retire = longp_wbck_valid && longp_wbck_ready;
  assign w_alu_hs = alu_wbck_valid && alu_wbck_ready;

  // Pointer update; reset discards every outstanding entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_alloc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_retire) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Entry storage; contents need no reset since validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_rdwen[w_wr_idx] <= disp_rdwen;
      r_rdidx[w_wr_idx] <= disp_rdidx;
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    for (int i = 0; i < OITF_DEPTH; i++) begin
      w_off[i]   = PTR_W'(i) - w_rd_idx;
      w_valid[i] = ({1'b0, w_off[i]} < w_count);
    end
  end

  // Hazard detection against every live entry that writes a non-x0 register.
  always_comb begin
    oitf_dep = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      if (w_valid[i] && r_rdwen[i] && (r_rdidx[i] != 5'd0)) begin
        if ((disp_rs1en && (disp_rs1idx == r_rdidx[i])) ||
            (disp_rs2en && (disp_rs2idx == r_rdidx[i])) ||
            (disp_rdwen && (disp_rdidx  == r_rdidx[i]))) begin
          oitf_dep = 1'b1;
        end
      end
    end
  end

  // Write port mux; writes to x0 complete the handshake but are suppressed.
  always_comb begin
    wbck_dest_wen = 1'b0;
    wbck_dest_idx = 5'd0;
    wbck_dest_dat = 32'd0;
    if (w_retire) begin
      wbck_dest_wen = r_rdwen[w_rd_idx] && (r_rdidx[w_rd_idx] != 5'd0) && !rst;
      wbck_dest_idx = r_rdidx[w_rd_idx];
      wbck_dest_dat = longp_wbck_dat;
    end else if (w_alu_hs) begin
      wbck_dest_wen = (alu_wbck_idx != 5'd0) && !rst;
      wbck_dest_idx = alu_wbck_idx;
      wbck_dest_dat = alu_wbck_dat;
    end
  end

endmodule
